// File: rtl/fft_pkg.sv
// Shared FFT/IFFT butterfly definitions: sample width, twiddle codes, scale constants, saturation helper.
package fft_pkg;

  localparam int FFT_DW = 9;

  // Twiddle magnitude codes; W_RSV is reserved and scales like W_ONE.
  localparam logic [1:0] W_ZERO = 2'd0;
  localparam logic [1:0] W_R2   = 2'd1;
  localparam logic [1:0] W_ONE  = 2'd2;
  localparam logic [1:0] W_RSV  = 2'd3;

  // Q8 scale factors: 0, 1/sqrt(2), 1.0
  localparam int K_ZERO   = 0;
  localparam int K_R2     = 181;
  localparam int K_ONE    = 256;
  localparam int TW_SHIFT = 8;

  typedef struct packed {
    logic [1:0] mag;
    logic       neg;
  } tw_t;

  function automatic int sat(input int v, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/twiddle_scale.sv
// Combinational twiddle component multiply: p = +/-((x*K) >>> 8), two guard bits so -(-256) holds.
module twiddle_scale
  import fft_pkg::*;
#(
  parameter int DW = FFT_DW
) (
  input  logic signed [DW-1:0] x,
  input  logic        [1:0]    mag,
  input  logic                 neg,
  output logic signed [DW+1:0] p
);

  localparam int PW = DW + 10;

  logic signed [PW-1:0] x_ext;
  logic signed [PW-1:0] k_ext;
  logic signed [DW+1:0] mag_p;

  always_comb begin
    x_ext = PW'(x);
    unique case (mag)
      W_ZERO:  k_ext = PW'(K_ZERO);
      W_R2:    k_ext = PW'(K_R2);
      default: k_ext = PW'(K_ONE);
    endcase
    // Arithmetic shift floors negative products toward -inf.
    mag_p = (DW + 2)'((x_ext * k_ext) >>> TW_SHIFT);
    p     = neg ? -mag_p : mag_p;
  end

endmodule

// File: rtl/ifft_butterfly.sv
// Radix-2 inverse DIF butterfly: xa=(ya+yb)/2, xb=((ya-yb)/2)*conj(W); 2-cycle latency, 1 beat/cycle.
// Backpressure is a global stall (o_valid && !i_ready) that freezes both stages.
module ifft_butterfly
  import fft_pkg::*;
#(
  parameter int DW    = FFT_DW,
  parameter bit HALVE = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic        [1:0]    i_w_re_mag,
  input  logic                 i_w_re_neg,
  input  logic        [1:0]    i_w_im_mag,
  input  logic                 i_w_im_neg,
  input  logic signed [DW-1:0] i_ya_re,
  input  logic signed [DW-1:0] i_ya_im,
  input  logic signed [DW-1:0] i_yb_re,
  input  logic signed [DW-1:0] i_yb_im,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic signed [DW-1:0] o_xa_re,
  output logic signed [DW-1:0] o_xa_im,
  output logic signed [DW-1:0] o_xb_re,
  output logic signed [DW-1:0] o_xb_im
);

  logic stall;
  logic accept;

  assign stall   = o_valid && !i_ready;
  assign o_ready = !stall;
  assign accept  = i_valid && o_ready;

  // Stage 1: sum / difference with optional halving
  function automatic logic signed [DW-1:0] scale1(input logic signed [DW:0] v);
    if (HALVE) return v[DW:1];
    else       return DW'(sat(int'(v), DW));
  endfunction

  logic signed [DW:0]   s_re, s_im, d_re, d_im;
  logic signed [DW-1:0] s1_xa_re, s1_xa_im, s1_d_re, s1_d_im;
  tw_t                  s1_w_re, s1_w_im;
  logic                 s1_vld;

  always_comb begin
    s_re = {i_ya_re[DW-1], i_ya_re} + {i_yb_re[DW-1], i_yb_re};
    s_im = {i_ya_im[DW-1], i_ya_im} + {i_yb_im[DW-1], i_yb_im};
    d_re = {i_ya_re[DW-1], i_ya_re} - {i_yb_re[DW-1], i_yb_re};
    d_im = {i_ya_im[DW-1], i_ya_im} - {i_yb_im[DW-1], i_yb_im};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_vld   <= 1'b0;
      s1_xa_re <= '0;
      s1_xa_im <= '0;
      s1_d_re  <= '0;
      s1_d_im  <= '0;
      s1_w_re  <= '0;
      s1_w_im  <= '0;
    end else if (!stall) begin
      s1_vld <= i_valid;
      if (accept) begin
        s1_xa_re <= scale1(s_re);
        s1_xa_im <= scale1(s_im);
        s1_d_re  <= scale1(d_re);
        s1_d_im  <= scale1(d_im);
        s1_w_re  <= '{mag: i_w_re_mag, neg: i_w_re_neg};
        s1_w_im  <= '{mag: i_w_im_mag, neg: i_w_im_neg};
      end
    end
  end

  // Stage 2: xb = d * conj(W)
  logic signed [DW+1:0] p_rr, p_ii, p_ir, p_ri;

  twiddle_scale #(.DW(DW)) u_ts_rr (.x(s1_d_re), .mag(s1_w_re.mag), .neg(s1_w_re.neg), .p(p_rr));
  twiddle_scale #(.DW(DW)) u_ts_ii (.x(s1_d_im), .mag(s1_w_im.mag), .neg(s1_w_im.neg), .p(p_ii));
  twiddle_scale #(.DW(DW)) u_ts_ir (.x(s1_d_im), .mag(s1_w_re.mag), .neg(s1_w_re.neg), .p(p_ir));
  twiddle_scale #(.DW(DW)) u_ts_ri (.x(s1_d_re), .mag(s1_w_im.mag), .neg(s1_w_im.neg), .p(p_ri));

  logic signed [DW+2:0]  xb_re_sum, xb_im_sum;
  logic signed [DW-1:0]  xb_re_n, xb_im_n;

  always_comb begin
    xb_re_sum = (DW + 3)'(p_rr) + (DW + 3)'(p_ii);
    xb_im_sum = (DW + 3)'(p_ir) - (DW + 3)'(p_ri);
    xb_re_n   = DW'(sat(int'(xb_re_sum), DW));
    xb_im_n   = DW'(sat(int'(xb_im_sum), DW));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_xa_re <= '0;
      o_xa_im <= '0;
      o_xb_re <= '0;
      o_xb_im <= '0;
    end else if (!stall) begin
      o_valid <= s1_vld;
      if (s1_vld) begin
        o_xa_re <= s1_xa_re;
        o_xa_im <= s1_xa_im;
        o_xb_re <= xb_re_n;
        o_xb_im <= xb_im_n;
      end
    end
  end

endmodule

// File: tb/tb_ifft_butterfly.sv
// Directed-vector bench for ifft_butterfly: arithmetic corners, backpressure ordering, mid-stream reset.
module tb_ifft_butterfly;

  localparam int DW = 9;

  logic                 i_clk = 1'b0;
  logic                 i_rst_n;
  logic                 i_valid;
  logic                 o_ready;
  logic        [1:0]    i_w_re_mag, i_w_im_mag;
  logic                 i_w_re_neg, i_w_im_neg;
  logic signed [DW-1:0] i_ya_re, i_ya_im, i_yb_re, i_yb_im;
  logic                 o_valid;
  logic                 i_ready;
  logic signed [DW-1:0] o_xa_re, o_xa_im, o_xb_re, o_xb_im;

  int n_chk  = 0;
  int n_fail = 0;

  ifft_butterfly #(.DW(DW), .HALVE(1'b1)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_w_re_mag (i_w_re_mag),
    .i_w_re_neg (i_w_re_neg),
    .i_w_im_mag (i_w_im_mag),
    .i_w_im_neg (i_w_im_neg),
    .i_ya_re    (i_ya_re),
    .i_ya_im    (i_ya_im),
    .i_yb_re    (i_yb_re),
    .i_yb_im    (i_yb_im),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_xa_re    (o_xa_re),
    .o_xa_im    (o_xa_im),
    .o_xb_re    (o_xb_re),
    .o_xb_im    (o_xb_im)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int ya_re, input int ya_im, input int yb_re, input int yb_im,
                       input int wr_mag, input int wr_neg, input int wi_mag, input int wi_neg);
    i_ya_re    = DW'(ya_re);
    i_ya_im    = DW'(ya_im);
    i_yb_re    = DW'(yb_re);
    i_yb_im    = DW'(yb_im);
    i_w_re_mag = 2'(wr_mag);
    i_w_re_neg = 1'(wr_neg);
    i_w_im_mag = 2'(wi_mag);
    i_w_im_neg = 1'(wi_neg);
  endtask

  task automatic chk_out(input string tag, input int xa_re, input int xa_im,
                         input int xb_re, input int xb_im);
    chk({tag, "_xa_re"}, int'(o_xa_re), xa_re);
    chk({tag, "_xa_im"}, int'(o_xa_im), xa_im);
    chk({tag, "_xb_re"}, int'(o_xb_re), xb_re);
    chk({tag, "_xb_im"}, int'(o_xb_im), xb_im);
  endtask

  // Single beat, no backpressure: must appear exactly two edges after acceptance.
  task automatic run_vec(input string tag,
                         input int ya_re, input int ya_im, input int yb_re, input int yb_im,
                         input int wr_mag, input int wr_neg, input int wi_mag, input int wi_neg,
                         input int xa_re, input int xa_im, input int xb_re, input int xb_im);
    drive(ya_re, ya_im, yb_re, yb_im, wr_mag, wr_neg, wi_mag, wi_neg);
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    chk({tag, "_lat1_vld"}, int'(o_valid), 0);
    @(negedge i_clk);
    chk({tag, "_vld"}, int'(o_valid), 1);
    chk_out(tag, xa_re, xa_im, xb_re, xb_im);
  endtask

  // Backpressure stream tables: W = 1.0, ya = (40+20k, 4k), yb = (20, 2)
  int bp_xa_re [4] = '{30, 40, 50, 60};
  int bp_xa_im [4] = '{1, 3, 5, 7};
  int bp_xb_re [4] = '{10, 20, 30, 40};
  int bp_xb_im [4] = '{-1, 1, 3, 5};
  int got_xa_re[4], got_xa_im[4], got_xb_re[4], got_xb_im[4];

  initial begin
    int idx, ngot;
    bit prev_stall, stall_now;
    int h_xa_re, h_xa_im, h_xb_re, h_xb_im;

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_vld", int'(o_valid), 0);
    chk("rst_rdy", int'(o_ready), 1);
    chk_out("rst", 0, 0, 0, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    run_vec("ident", 100, 0, 20, 0,  2, 0, 0, 0,  60, 0, 40, 0);
    run_vec("conj",  100, 0, 20, 0,  0, 0, 2, 1,  60, 0, 0, 40);
    run_vec("round", -3, 0, 0, 0,    2, 0, 0, 0,  -2, 0, -2, 0);
    run_vec("sat",   255, 255, -256, -256,  1, 0, 1, 1,  -1, -1, 0, 255);
    // Reserved code 3 scales like 1.0; -1.0 real negates d.
    run_vec("rsv",   50, -30, 10, 10,  3, 1, 0, 0,  30, -10, -20, 20);

    // Backpressure: i_ready low in iterations 2..5 of the stream
    idx = 0;
    ngot = 0;
    prev_stall = 1'b0;
    h_xa_re = 0; h_xa_im = 0; h_xb_re = 0; h_xb_im = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge i_clk);
      if (prev_stall) begin
        chk("bp_hold_vld", int'(o_valid), 1);
        chk_out("bp_hold", h_xa_re, h_xa_im, h_xb_re, h_xb_im);
      end
      i_ready = !(c >= 2 && c <= 5);
      if (idx < 4) begin
        drive(40 + 20 * idx, 4 * idx, 20, 2, 2, 0, 0, 0);
        i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      #1;
      stall_now = o_valid && !i_ready;
      if (stall_now) chk("bp_rdy_low", int'(o_ready), 0);
      if (o_valid && i_ready) begin
        if (ngot < 4) begin
          got_xa_re[ngot] = int'(o_xa_re);
          got_xa_im[ngot] = int'(o_xa_im);
          got_xb_re[ngot] = int'(o_xb_re);
          got_xb_im[ngot] = int'(o_xb_im);
        end
        ngot++;
      end
      if (i_valid && o_ready) idx++;
      prev_stall = stall_now;
      h_xa_re = int'(o_xa_re);
      h_xa_im = int'(o_xa_im);
      h_xb_re = int'(o_xb_re);
      h_xb_im = int'(o_xb_im);
    end
    chk("bp_accepted", idx, 4);
    chk("bp_count", ngot, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < ngot) begin
        chk($sformatf("bp%0d_xa_re", k), got_xa_re[k], bp_xa_re[k]);
        chk($sformatf("bp%0d_xa_im", k), got_xa_im[k], bp_xa_im[k]);
        chk($sformatf("bp%0d_xb_re", k), got_xb_re[k], bp_xb_re[k]);
        chk($sformatf("bp%0d_xb_im", k), got_xb_im[k], bp_xb_im[k]);
      end
    end

    // Reset with two beats in flight
    @(negedge i_clk);
    i_ready = 1'b1;
    drive(100, 0, 20, 0, 2, 0, 0, 0);
    i_valid = 1'b1;
    @(negedge i_clk);
    drive(60, 10, 20, 10, 2, 0, 0, 0);
    @(negedge i_clk);
    chk("mid_pre_vld", int'(o_valid), 1);
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    chk("mid_rst_vld", int'(o_valid), 0);
    chk("mid_rst_rdy", int'(o_ready), 1);
    chk_out("mid_rst", 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      chk($sformatf("mid_stale%0d", c), int'(o_valid), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ifft_butterfly.md
Name: ifft_butterfly

Overview:
- Pipelined radix-2 inverse (decimation-in-frequency) butterfly. It undoes the forward butterfly: xa = (ya + yb)/2 and xb = ((ya - yb)/2) * conj(W).
- Sits in the IFFT datapath, fed by the stage sequencer with one butterfly pair per beat.
- Uses the same 9-bit signed complex sample format and the same twiddle encoding (2-bit magnitude plus negate flag) as the forward path.
- Valid/ready handshake on both sides; 2-stage pipeline.

Parameters:
- DW, 9, sample width (signed, per real/imag component)
- HALVE, 1, 1 = apply the /2 scaling in stage 1; 0 = no scaling (sum/diff saturated to DW)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept a beat this cycle
- i_w_re_mag  in  2  twiddle real magnitude code
- i_w_re_neg  in  1  twiddle real sign (1 = negative)
- i_w_im_mag  in  2  twiddle imag magnitude code
- i_w_im_neg  in  1  twiddle imag sign
- i_ya_re, i_ya_im, i_yb_re, i_yb_im  in  DW each  signed input pair
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts
- o_xa_re, o_xa_im, o_xb_re, o_xb_im  out  DW each  signed output pair

Behaviour:
- Reset and clock: one clock i_clk; reset i_rst_n is synchronous, active-low.
- Reset values: all valid flags and all data/twiddle registers clear to 0. So o_valid=0 and outputs are 0 after reset. o_ready is 1 after reset.
- Reset mid-operation: beats in flight are dropped with no partial output.
- Twiddle scaling: each code is applied as p = (x*K)>>>8 with K = 0/181/256/256 for codes 0/1/2/3. Code 3 is reserved and behaves as 1.0. If neg=1, then p = -p.
  - Compute p in DW+2 bits so that -(-256) does not wrap.
- Stage 1 (accept when i_valid && o_ready):
  - s = ya + yb and d = ya - yb, each component in DW+1 bits.
  - HALVE=1: store s>>>1 and d>>>1 (arithmetic, floor). These always fit DW.
  - HALVE=0: store s and d saturated to [-2^(DW-1), 2^(DW-1)-1].
  - Twiddle fields are registered alongside the data.
- Stage 2: xa is passed through from stage 1. xb = d * conj(W):
  - xb_re = P(d_re, w_re) + P(d_im, w_im)
  - xb_im = P(d_im, w_re) - P(d_re, w_im)
  - P(x, w) is the signed scaling above, with w's mag/neg.
  - Sums use DW+3 bits, then saturate to DW range.
- Latency: 2 cycles from accepted input to o_valid when there is no backpressure. Throughput is 1 beat/cycle.
- Handshake:
  - Global stall: stall = o_valid && !i_ready. o_ready = !stall.
  - When stalled, both stages hold data and valid; outputs are stable.
  - Bubbles propagate. The stage-2 valid loads from the stage-1 valid whenever not stalled.
  - Simultaneous accept and drain in the same cycle is legal (full throughput).
- o_valid must never drop without i_ready. Output data is unchanged while o_valid && !i_ready.

Decomposition:
- Shared package fft_pkg holds:
  - DW default
  - twiddle magnitude code constants (W_ZERO=0, W_R2=1, W_ONE=2, W_RSV=3)
  - the scale constants 0/181/256
  - a saturate function used by both butterflies
- One sub-module, twiddle_scale: combinational x, mag, neg -> DW+2-bit product. It is instantiated 4x in stage 2.

Test Plan:
- Identity: ya=(100,0), yb=(20,0), W=(mag2,+ , mag0) -> after 2 cycles xa=(60,0), xb=(40,0).
- Conjugate rotation: ya=(100,0), yb=(20,0), W=(re mag0, im mag2 neg1) i.e. -j -> xa=(60,0), xb=(0,40).
- Rounding: ya=(-3,0), yb=(0,0), W=1 -> xa=(-2,0), xb=(-2,0).
- Saturation:
  - Stimulus: ya=(255,255), yb=(-256,-256), W=(mag1,+ , mag1,neg1).
  - d=(255,255) gives 180 per product.
  - Required response: xa=(-1,-1), xb=(0,255) (im 360 saturated).
- Backpressure: stream 4 beats with i_ready=0 for cycles 2-5.
  - o_ready=0 while stalled and o_valid held with stable data.
  - All 4 beats emerge in order, none lost or duplicated.
- Reset mid-stream: assert i_rst_n=0 for 1 cycle with 2 beats in flight -> next cycle o_valid=0, o_ready=1, outputs 0, and no stale beat appears afterwards.
